// File: rtl/sdes_collect_pkg.sv
// Shared types and default sizing for the serial-to-word collector.
package sdes_collect_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/sdes_collect_if.sv
// Bit-input and word-output bundle between the collector and its environment.
interface sdes_collect_if
    import sdes_collect_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();

    logic                   bit_vld;
    logic                   bit_in;
    logic                   dir;
    logic                   clr;
    logic                   out_rdy;
    logic [WIDTH-1:0]       out_data;
    logic                   out_vld;
    logic [$clog2(DEPTH):0] level;
    logic                   busy;
    logic                   ovf;

    modport master (
        output bit_vld, bit_in, dir, clr, out_rdy,
        input  out_data, out_vld, level, busy, ovf
    );

    modport slave (
        input  bit_vld, bit_in, dir, clr, out_rdy,
        output out_data, out_vld, level, busy, ovf
    );

endinterface

// File: rtl/sdes_collect_fifo.sv
// Word buffer with a registered head word, so out_data/out_vld come straight from flops.
module sdes_fifo
    import sdes_collect_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_vld,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [WIDTH-1:0] head_r;
    logic             vld_r;

    logic             do_pop_s;
    logic             do_push_s;
    logic [LW-1:0]    level_nxt_s;
    logic [WIDTH-1:0] head_nxt_s;

    assign empty    = (level_r == LW'(1'b0));
    assign full     = (level_r == LW'(DEPTH));
    assign out_data = head_r;
    assign out_vld  = vld_r;
    assign level    = level_r;

    // Accept/remove decisions, next occupancy and the word that will sit at the head.
    always_comb begin
        do_pop_s    = pop && !empty;
        do_push_s   = push && (!full || do_pop_s);
        level_nxt_s = level_r;
        head_nxt_s  = head_r;

        if (do_push_s && !do_pop_s) begin
            level_nxt_s = level_r + LW'(1'b1);
        end else if (do_pop_s && !do_push_s) begin
            level_nxt_s = level_r - LW'(1'b1);
        end else begin
            level_nxt_s = level_r;
        end

        // When the popped entry was the last stored one, the incoming word becomes the head.
        if (do_pop_s) begin
            if (level_r > LW'(1'b1)) begin
                head_nxt_s = mem_r[rd_ptr_r + AW'(1'b1)];
            end else if (do_push_s) begin
                head_nxt_s = push_data;
            end else begin
                head_nxt_s = head_r;
            end
        end else if (empty && do_push_s) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Storage, pointers and registered head/valid/level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            head_r   <= {WIDTH{1'b0}};
            vld_r    <= 1'b0;
        end else if (clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            head_r   <= {WIDTH{1'b0}};
            vld_r    <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            level_r <= level_nxt_s;
            head_r  <= head_nxt_s;
            vld_r   <= (level_nxt_s != LW'(1'b0));
        end
    end

endmodule

// File: rtl/sdes_collect.sv
// Assembles serial bits into WIDTH-bit words (MSB- or LSB-first) and queues them for downstream.
module sdes_collect
    import sdes_collect_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          reset_n,
    sdes_collect_if.slave bus
);

    localparam int CW   = $clog2(WIDTH) + 1;
    localparam int LAST = WIDTH - 1;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_nxt_s;
    logic             dir_q_r;
    logic             dir_q_nxt_s;
    logic             busy_r;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             shift_dir_s;
    logic [WIDTH-1:0] shifted_s;
    logic             push_s;
    logic             pop_req_s;
    logic             full_s;
    logic             empty_s;

    function automatic logic [WIDTH-1:0] shift_in(
        input logic [WIDTH-1:0] cur,
        input logic             b,
        input logic             d
    );
        logic [WIDTH-1:0] r;
        if (d == 1'b0) begin
            r    = cur << 1'b1;
            r[0] = b;
        end else begin
            r          = cur >> 1'b1;
            r[WIDTH-1] = b;
        end
        return r;
    endfunction

    assign pop_req_s = !empty_s && bus.out_rdy;
    assign bus.busy  = busy_r;
    assign bus.ovf   = ovf_r;

    // Assembly FSM: the first bit of a word uses the live dir, later bits the latched one.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        shreg_nxt_s = shreg_r;
        dir_q_nxt_s = dir_q_r;
        push_s      = 1'b0;
        shift_dir_s = (state_r == IDLE) ? bus.dir : dir_q_r;
        shifted_s   = shift_in(shreg_r, bus.bit_in, shift_dir_s);

        if (bus.clr) begin
            state_nxt_s = IDLE;
            count_nxt_s = {CW{1'b0}};
            shreg_nxt_s = {WIDTH{1'b0}};
        end else if (bus.bit_vld) begin
            case (state_r)
                IDLE: begin
                    dir_q_nxt_s = bus.dir;
                    if (WIDTH == 32'sd1) begin
                        push_s      = 1'b1;
                        state_nxt_s = IDLE;
                        count_nxt_s = {CW{1'b0}};
                        shreg_nxt_s = {WIDTH{1'b0}};
                    end else begin
                        state_nxt_s = COLLECT;
                        count_nxt_s = CW'(1'b1);
                        shreg_nxt_s = shifted_s;
                    end
                end
                COLLECT: begin
                    if (count_r == CW'(LAST)) begin
                        push_s      = 1'b1;
                        state_nxt_s = IDLE;
                        count_nxt_s = {CW{1'b0}};
                        shreg_nxt_s = {WIDTH{1'b0}};
                    end else begin
                        state_nxt_s = COLLECT;
                        count_nxt_s = count_r + CW'(1'b1);
                        shreg_nxt_s = shifted_s;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    count_nxt_s = {CW{1'b0}};
                    shreg_nxt_s = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end

        // A word completing into a full buffer with no simultaneous pop is lost.
        if (bus.clr) begin
            ovf_nxt_s = 1'b0;
        end else if (push_s && full_s && !pop_req_s) begin
            ovf_nxt_s = 1'b1;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Assembly state and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            count_r <= {CW{1'b0}};
            shreg_r <= {WIDTH{1'b0}};
            dir_q_r <= 1'b0;
            busy_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            shreg_r <= shreg_nxt_s;
            dir_q_r <= dir_q_nxt_s;
            busy_r  <= (count_nxt_s != {CW{1'b0}});
            ovf_r   <= ovf_nxt_s;
        end
    end

    sdes_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (bus.clr),
        .push      (push_s),
        .push_data (shifted_s),
        .pop       (pop_req_s),
        .out_data  (bus.out_data),
        .out_vld   (bus.out_vld),
        .level     (bus.level),
        .full      (full_s),
        .empty     (empty_s)
    );

endmodule
